// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_e;

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog: counts busy cycles since the last grant and raises a sticky error.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic busy,
  output logic timeout,
  output logic err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // The grant cycle counts as the first elapsed cycle, so firing at TIMEOUT-2
  // lands err and the return to IDLE exactly TIMEOUT cycles after the grant.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = busy & ~clear & (cnt_q == CntW'(TIMEOUT - 2));
    if (clear) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CntW'(1);
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  input  logic              e_br_taken,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  arb_state_e state_q, state_d;
  logic       drop_q, drop_d;
  logic       busy, can_grant, d_gnt, timeout;

  always_comb begin
    busy      = (state_q != IDLE);
    d_rvalid  = (state_q == BUSY_D) & mem_rvalid;
    if_rvalid = (state_q == BUSY_I) & mem_rvalid & ~drop_q & ~e_br_taken;
    can_grant = (state_q == IDLE) | (busy & mem_rvalid);
    // d_req is still high in its own completion cycle; do not re-issue it.
    d_gnt     = can_grant & d_req & ~d_rvalid;
    if_gnt    = can_grant & if_req & ~d_gnt & ~e_br_taken;

    mem_req   = d_gnt | if_gnt;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    if (d_gnt) begin
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_size  = d_size;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      mem_size  = SIZE_W;
    end

    stall_mem = d_req & ~d_rvalid;
    stall_if  = if_req & ~if_rvalid;
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (state_q == BUSY_I) begin
      if (mem_rvalid) begin
        drop_d = 1'b0;
      end else if (e_br_taken) begin
        drop_d = 1'b1;
      end
    end
    if (can_grant) begin
      state_d = d_gnt ? BUSY_D : (if_gnt ? BUSY_I : IDLE);
    end
    if (timeout) begin
      state_d = IDLE;
      drop_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (mem_req),
    .busy    (busy),
    .timeout (timeout),
    .err     (err)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        e_br_taken = 1'b0;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem, err;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: answers addr ^ 0xC0DE0000 exactly lat cycles after the grant cycle.
  int          lat = 1;
  bit          resp_en = 1'b1;
  logic        pend = 1'b0;
  int          age = 0;
  logic [31:0] cap_addr = '0;

  assign mem_rvalid = pend && resp_en && (age == lat);
  assign mem_rdata  = mem_rvalid ? (cap_addr ^ 32'hC0DE_0000) : 32'h0;

  always @(posedge clk) begin
    if (mem_req) begin
      pend     <= 1'b1;
      age      <= 1;
      cap_addr <= mem_addr;
    end else if (mem_rvalid) begin
      pend <= 1'b0;
    end else if (pend) begin
      age <= age + 1;
    end
  end

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AWIDTH  (32),
    .DWIDTH  (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_wen      (d_wen),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_size     (d_size),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .e_br_taken (e_br_taken),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .err        (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, if_gnt, if_rvalid, d_rvalid, stall_if, stall_mem, err} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {mem_req, if_gnt, if_rvalid, d_rvalid, stall_if, stall_mem, err});
    end
  endtask

  task automatic test_fetch;
    tick();
    lat = 2;
    if_req = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt, mem_req, mem_wen, mem_size, stall_if} !== 6'b110101) begin
      n_bad++;
      $display("FAIL fetch_grant: got %b want 110101",
               {if_gnt, mem_req, mem_wen, mem_size, stall_if});
    end
    n_cmp++;
    if (mem_addr !== 32'h100) begin
      n_bad++;
      $display("FAIL fetch_addr: got %h want 00000100", mem_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({if_gnt, if_rvalid, stall_if} !== 3'b001) begin
      n_bad++;
      $display("FAIL fetch_wait: got %b want 001", {if_gnt, if_rvalid, stall_if});
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if_rvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_rvalid: got %b want 1", if_rvalid);
    end
    n_cmp++;
    if (if_rdata !== 32'hC0DE_0100) begin
      n_bad++;
      $display("FAIL fetch_rdata: got %h want c0de0100", if_rdata);
    end
  endtask

  task automatic test_priority;
    tick();
    lat = 1;
    if_req = 1'b1;
    if_addr = 32'h104;
    d_req = 1'b1;
    d_wen = 1'b0;
    d_addr = 32'h2000;
    d_size = 2'd2;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, if_gnt, stall_if, stall_mem} !== 4'b1011) begin
      n_bad++;
      $display("FAIL prio_data_first: got %b want 1011", {mem_req, if_gnt, stall_if, stall_mem});
    end
    n_cmp++;
    if (mem_addr !== 32'h2000) begin
      n_bad++;
      $display("FAIL prio_data_addr: got %h want 00002000", mem_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({d_rvalid, if_gnt, stall_mem, stall_if} !== 4'b1101) begin
      n_bad++;
      $display("FAIL prio_handover: got %b want 1101", {d_rvalid, if_gnt, stall_mem, stall_if});
    end
    n_cmp++;
    if ({d_rdata, mem_addr} !== {32'hC0DE_2000, 32'h104}) begin
      n_bad++;
      $display("FAIL prio_rdata_next_addr: got %h %h want c0de2000 00000104", d_rdata, mem_addr);
    end
    tick();
    d_req = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0104}) begin
      n_bad++;
      $display("FAIL prio_fetch_data: got %b %h want 1 c0de0104", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_branch_drop;
    tick();
    lat = 3;
    if_req = 1'b1;
    if_addr = 32'h200;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL br_first_grant: got %b want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    e_br_taken = 1'b1;
    tick();
    e_br_taken = 1'b0;
    tick();
    if_req = 1'b1;
    if_addr = 32'h300;
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, if_gnt} !== 2'b01) begin
      n_bad++;
      $display("FAIL br_stale_dropped: got %b want 01", {if_rvalid, if_gnt});
    end
    n_cmp++;
    if (mem_addr !== 32'h300) begin
      n_bad++;
      $display("FAIL br_new_addr: got %h want 00000300", mem_addr);
    end
    tick();
    if_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hC0DE_0300}) begin
      n_bad++;
      $display("FAIL br_new_data: got %b %h want 1 c0de0300", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store;
    tick();
    lat = 2;
    d_req = 1'b1;
    d_wen = 1'b1;
    d_size = 2'd0;
    d_addr = 32'h3001;
    d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_wen, mem_size, stall_mem} !== 5'b11001) begin
      n_bad++;
      $display("FAIL store_fields: got %b want 11001", {mem_req, mem_wen, mem_size, stall_mem});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== {32'h3001, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL store_addr_data: got %h %h want 00003001 deadbeef", mem_addr, mem_wdata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({stall_mem, d_rvalid, if_rvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL store_wait: got %b want 100", {stall_mem, d_rvalid, if_rvalid});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({stall_mem, d_rvalid, if_rvalid} !== 3'b010) begin
      n_bad++;
      $display("FAIL store_ack: got %b want 010", {stall_mem, d_rvalid, if_rvalid});
    end
    tick();
    d_req = 1'b0;
    d_wen = 1'b0;
  endtask

  task automatic test_timeout;
    int early_err;
    early_err = 0;
    lat = 1;
    resp_en = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h400;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_grant: got %b want 1", if_gnt);
    end
    tick();
    if_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (err !== 1'b0) early_err++;
      tick();
    end
    n_cmp++;
    if (early_err != 0) begin
      n_bad++;
      $display("FAIL wd_early_err: got %0d cycles with err want 0", early_err);
    end
    resp_en = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h500;
    @(negedge clk);
    n_cmp++;
    if ({err, if_gnt} !== 2'b11) begin
      n_bad++;
      $display("FAIL wd_err_and_regrant: got %b want 11", {err, if_gnt});
    end
    tick();
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({err, if_rvalid, if_rdata} !== {1'b1, 1'b1, 32'hC0DE_0500}) begin
      n_bad++;
      $display("FAIL wd_after_data: got %b %b %h want 1 1 c0de0500", err, if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_clears_err: got %b want 0", err);
    end
    tick();
    lat = 3;
    d_req = 1'b1;
    d_wen = 1'b0;
    d_addr = 32'h600;
    d_size = 2'd2;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_grant: got %b want 1", mem_req);
    end
    tick();
    reset = 1'b1;
    d_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req, if_gnt, if_rvalid, d_rvalid, stall_if, stall_mem, err} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %b want 0000000",
               {mem_req, if_gnt, if_rvalid, d_rvalid, stall_if, stall_mem, err});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({d_rvalid, if_rvalid, stall_mem} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_late_rvalid: got %b want 000", {d_rvalid, if_rvalid, stall_mem});
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_branch_drop();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
